// File: rtl/fetch_unit_if.sv
// Instruction-bus handshake between the fetch stage (master) and the
// instruction memory (slave). Signal names follow the master's view.
interface fetch_unit_if #(
  parameter int PC_W = 12
) ();
  logic            inst_cyc_o;
  logic            inst_stb_o;
  logic [PC_W-1:0] inst_adr_o;
  logic            inst_ack_i;

  modport master (output inst_cyc_o, inst_stb_o, inst_adr_o, input inst_ack_i);
  modport slave  (input inst_cyc_o, inst_stb_o, inst_adr_o, output inst_ack_i);
endinterface

// File: rtl/fetch_unit.sv
// Gumnut instruction-fetch stage: program counter, return stack and
// instruction-bus master. All state advances only when ClkEn_i is high.
module fetch_unit #(
  parameter int              PC_W        = 12,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [PC_W-1:0] INT_VECTOR  = PC_W'(1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ClkEn_i,
  input  logic            fetch_req_i,
  input  logic [2:0]      pc_c_i,
  input  logic [PC_W-1:0] addr_i,
  input  logic [7:0]      disp_i,
  fetch_unit_if.master    bus,
  output logic            fetch_done_o,
  output logic [PC_W-1:0] pc_o,
  output logic            stk_full_o,
  output logic            stk_empty_o,
  output logic            stk_err_o
);
  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W:0] SP_ONE  = (SP_W+1)'(1);
  localparam logic [SP_W:0] SP_FULL = (SP_W+1)'(STACK_DEPTH);

  localparam logic [2:0] C_BR   = 3'd1;
  localparam logic [2:0] C_JMP  = 3'd2;
  localparam logic [2:0] C_JSB  = 3'd3;
  localparam logic [2:0] C_RET  = 3'd4;
  localparam logic [2:0] C_RETI = 3'd5;
  localparam logic [2:0] C_INT  = 3'd6;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [SP_W:0]     r_sp;
  logic [PC_W-1:0]   r_stk [STACK_DEPTH];
  logic              r_done;
  logic              r_err;

  state_t            w_state_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_err_set;
  logic              w_done_nxt;
  logic              w_full;
  logic              w_empty;
  logic [SP_W-1:0]   w_top;
  logic [PC_W-1:0]   w_disp_ext;

  assign w_full     = (r_sp == SP_FULL);
  assign w_empty    = (r_sp == '0);
  assign w_top      = SP_W'(r_sp - SP_ONE);
  assign w_disp_ext = PC_W'($signed(disp_i));

  // The PC command is resolved before a same-cycle fetch request, so the
  // first bus address is already the updated PC.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        case (pc_c_i)
          C_BR:  w_pc_nxt = r_pc + w_disp_ext;
          C_JMP: w_pc_nxt = addr_i;
          C_JSB, C_INT: begin
            w_pc_nxt = (pc_c_i == C_JSB) ? addr_i : INT_VECTOR;
            if (w_full) w_err_set = 1'b1;
            else        w_push    = 1'b1;
          end
          C_RET, C_RETI: begin
            if (w_empty) begin
              w_err_set = 1'b1;
            end else begin
              w_pop    = 1'b1;
              w_pc_nxt = r_stk[w_top];
            end
          end
          default: ;
        endcase
        if (fetch_req_i) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (bus.inst_ack_i) begin
          w_pc_nxt    = r_pc + PC_W'(1);
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_sp    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (ClkEn_i) begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_done  <= w_done_nxt;
      if (w_push)     r_sp <= r_sp + SP_ONE;
      else if (w_pop) r_sp <= r_sp - SP_ONE;
      if (w_err_set)  r_err <= 1'b1;
    end
  end

  // Stack storage needs no reset: an entry is only read after it was pushed.
  always_ff @(posedge clk_i) begin
    if (ClkEn_i && w_push) r_stk[r_sp[SP_W-1:0]] <= r_pc;
  end

  assign bus.inst_cyc_o = (r_state == S_FETCH);
  assign bus.inst_stb_o = (r_state == S_FETCH);
  assign bus.inst_adr_o = r_pc;
  assign fetch_done_o   = r_done;
  assign pc_o           = r_pc;
  assign stk_full_o     = w_full;
  assign stk_empty_o    = w_empty;
  assign stk_err_o      = r_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: command table, stack overflow/underflow, clock-enable
// freeze during a waited fetch and asynchronous reset mid-fetch.
module tb_fetch_unit;
  localparam logic [2:0] C_NOP = 3'd0, C_BR = 3'd1, C_JMP = 3'd2, C_JSB = 3'd3,
                         C_RET = 3'd4, C_RETI = 3'd5, C_INT = 3'd6, C_RSV = 3'd7;

  logic        clk, rst_n, clk_en, fetch_req;
  logic [2:0]  pc_c;
  logic [11:0] addr;
  logic [7:0]  disp;
  logic        fetch_done, stk_full, stk_empty, stk_err;
  logic [11:0] pc;

  fetch_unit_if #(.PC_W(12)) bus ();

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst_n), .ClkEn_i(clk_en), .fetch_req_i(fetch_req),
    .pc_c_i(pc_c), .addr_i(addr), .disp_i(disp), .bus(bus),
    .fetch_done_o(fetch_done), .pc_o(pc), .stk_full_o(stk_full),
    .stk_empty_o(stk_empty), .stk_err_o(stk_err)
  );

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0;
  int ws_cfg = 0, ws_cnt = 0;
  logic [11:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Slave with ws_cfg wait states; the scoreboard pops the expected address
  // whenever the next rising edge will accept an ack.
  always @(negedge clk) begin
    if (!bus.inst_cyc_o) begin
      bus.inst_ack_i = 1'b0;
      ws_cnt = 0;
    end else if (!bus.inst_ack_i && clk_en) begin
      if (ws_cnt == ws_cfg) bus.inst_ack_i = 1'b1;
      else ws_cnt++;
    end
    if (bus.inst_cyc_o && bus.inst_ack_i && clk_en) begin
      if (exp_q.size() == 0) chk("unexpected_fetch", 32'd1, 32'd0);
      else chk("fetch_adr", 32'(bus.inst_adr_o), 32'(exp_q.pop_front()));
    end
    if (fetch_done) done_cnt++;
  end

  task automatic wait_idle();
    for (int k = 0; k < 64 && bus.inst_cyc_o; k++) tick();
    chk("fetch_timeout", 32'(bus.inst_cyc_o), 32'd0);
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [11:0] a);
    pc_c = c; addr = a;
    tick();
    pc_c = C_NOP;
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [11:0] addr;
    logic [7:0]  disp;
    logic        fetch;
    logic [11:0] exp_adr;
    logic [11:0] exp_pc;
    logic        exp_empty;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [11:0] mpc;
    logic [11:0] stk_m [$];
    int d0;

    vecs[0]  = '{C_NOP,  12'h000, 8'h00, 1'b1, 12'h000, 12'h001, 1'b1};
    vecs[1]  = '{C_JMP,  12'h010, 8'h00, 1'b0, 12'h000, 12'h010, 1'b1};
    vecs[2]  = '{C_BR,   12'h000, 8'h05, 1'b1, 12'h015, 12'h016, 1'b1};
    vecs[3]  = '{C_BR,   12'h000, 8'hFC, 1'b0, 12'h000, 12'h012, 1'b1};
    vecs[4]  = '{C_JMP,  12'h002, 8'h00, 1'b0, 12'h000, 12'h002, 1'b1};
    vecs[5]  = '{C_BR,   12'h000, 8'hFC, 1'b0, 12'h000, 12'hFFE, 1'b1};
    vecs[6]  = '{C_BR,   12'h000, 8'h01, 1'b0, 12'h000, 12'hFFF, 1'b1};
    vecs[7]  = '{C_NOP,  12'h000, 8'h00, 1'b1, 12'hFFF, 12'h000, 1'b1};
    vecs[8]  = '{C_JMP,  12'h031, 8'h00, 1'b0, 12'h000, 12'h031, 1'b1};
    vecs[9]  = '{C_JSB,  12'h200, 8'h00, 1'b1, 12'h200, 12'h201, 1'b0};
    vecs[10] = '{C_RET,  12'h000, 8'h00, 1'b0, 12'h000, 12'h031, 1'b1};
    vecs[11] = '{C_RSV,  12'h555, 8'h7F, 1'b0, 12'h000, 12'h031, 1'b1};
    vecs[12] = '{C_INT,  12'h000, 8'h00, 1'b0, 12'h000, 12'h001, 1'b0};
    vecs[13] = '{C_RETI, 12'h000, 8'h00, 1'b0, 12'h000, 12'h031, 1'b1};
    vecs[14] = '{C_INT,  12'h777, 8'h00, 1'b1, 12'h001, 12'h002, 1'b0};
    vecs[15] = '{C_RET,  12'h000, 8'h00, 1'b0, 12'h000, 12'h031, 1'b1};

    rst_n = 1'b0; clk_en = 1'b1; fetch_req = 1'b0;
    pc_c = C_NOP; addr = '0; disp = '0;
    tick(); tick();
    rst_n = 1'b1;

    chk("rst_pc",    32'(pc),             32'h000);
    chk("rst_adr",   32'(bus.inst_adr_o), 32'h000);
    chk("rst_cyc",   32'(bus.inst_cyc_o), 32'd0);
    chk("rst_stb",   32'(bus.inst_stb_o), 32'd0);
    chk("rst_done",  32'(fetch_done),     32'd0);
    chk("rst_empty", 32'(stk_empty),      32'd1);
    chk("rst_full",  32'(stk_full),       32'd0);
    chk("rst_err",   32'(stk_err),        32'd0);

    for (int i = 0; i < 16; i++) begin
      pc_c = vecs[i].cmd; addr = vecs[i].addr; disp = vecs[i].disp;
      fetch_req = vecs[i].fetch;
      if (vecs[i].fetch) exp_q.push_back(vecs[i].exp_adr);
      tick();
      pc_c = C_NOP; fetch_req = 1'b0;
      if (vecs[i].fetch) begin
        chk("vec_stb", 32'(bus.inst_stb_o), 32'd1);
        wait_idle();
        chk("vec_done", 32'(fetch_done), 32'd1);
      end
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d_empty", i), 32'(stk_empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_err", i), 32'(stk_err), 32'd0);
    end
    tick();
    chk("table_done_count", 32'(done_cnt), 32'd5);

    // Overflow then underflow of the return stack.
    do_cmd(C_JMP, 12'h100);
    mpc = 12'h100;
    for (int i = 1; i <= 9; i++) begin
      if (stk_m.size() < 8) stk_m.push_back(mpc);
      mpc = 12'h100 + 12'(i * 16);
      do_cmd(C_JSB, mpc);
      chk($sformatf("jsb%0d_pc", i), 32'(pc), 32'(mpc));
      if (i == 8) begin
        chk("full_after_8", 32'(stk_full), 32'd1);
        chk("err_after_8",  32'(stk_err),  32'd0);
      end
      if (i == 9) begin
        chk("full_after_9", 32'(stk_full), 32'd1);
        chk("err_after_9",  32'(stk_err),  32'd1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      mpc = stk_m.pop_back();
      do_cmd(C_RET, 12'h000);
      chk($sformatf("ret%0d_pc", i), 32'(pc), 32'(mpc));
    end
    chk("empty_after_8_ret", 32'(stk_empty), 32'd1);
    do_cmd(C_RET, 12'h000);
    chk("underflow_pc",    32'(pc),        32'h100);
    chk("underflow_empty", 32'(stk_empty), 32'd1);
    chk("underflow_err",   32'(stk_err),   32'd1);

    // Waited fetch with clock enable dropped and a JMP offered during FETCH.
    ws_cfg = 3;
    d0 = done_cnt;
    exp_q.push_back(12'h040);
    pc_c = C_JMP; addr = 12'h040; fetch_req = 1'b1;
    tick();
    addr = 12'h300;
    tick();
    chk("fetch_jmp_ignored", 32'(pc), 32'h040);
    tick();
    pc_c = C_NOP; fetch_req = 1'b0; clk_en = 1'b0;
    tick();
    chk("frozen_pc_a",  32'(pc),             32'h040);
    chk("frozen_cyc_a", 32'(bus.inst_cyc_o), 32'd1);
    tick();
    chk("frozen_pc_b",  32'(pc),             32'h040);
    chk("frozen_cyc_b", 32'(bus.inst_cyc_o), 32'd1);
    clk_en = 1'b1;
    wait_idle();
    chk("waited_pc", 32'(pc), 32'h041);
    tick(); tick();
    chk("waited_done_once", 32'(done_cnt - d0), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while the bus cycle is active.
    exp_q.push_back(12'h041);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("pre_reset_cyc", 32'(bus.inst_cyc_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc",   32'(bus.inst_cyc_o), 32'd0);
    chk("async_rst_stb",   32'(bus.inst_stb_o), 32'd0);
    chk("async_rst_pc",    32'(pc),             32'h000);
    chk("async_rst_err",   32'(stk_err),        32'd0);
    chk("async_rst_empty", 32'(stk_empty),      32'd1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_pc", 32'(pc), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
